// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the two-master Wishbone arbiter.
// Grant states use one-hot codes so the state register doubles as the grant vector.
package wb_arb_pkg;
  localparam int SEL_W = 4;
  localparam int DAT_W = 32;
  localparam int ADR_W = 32;
  localparam logic [DAT_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wb_req_t;
endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transfer watchdog: counts unacknowledged strobe cycles and flags a timeout combinationally.
// The timeout event is recorded in a sticky flag and a saturating counter at the next edge.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             ack,
  input  logic             gnt_chg,
  input  logic             clr,
  output logic             timeout,
  output logic             flag,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] wait_cnt;

  // Ack on the deadline cycle takes precedence over the abort.
  assign timeout = req & ~ack & (wait_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (!req || ack || timeout || gnt_chg) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // A clear coinciding with a timeout still records that timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
      cnt  <= '0;
    end else if (clr) begin
      flag <= timeout;
      cnt  <= timeout ? CNT_W'(1) : '0;
    end else if (timeout) begin
      flag <= 1'b1;
      cnt  <= (&cnt) ? cnt : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin, cycle-locked arbiter sharing one Wishbone slave port between CPU (m0) and DMA (m1).
// One cycle from cyc to grant; the losing master is stalled with no ack until the winner drops cyc.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int               TIMEOUT_CYC = 64,
  parameter logic [DAT_W-1:0] ERR_DATA    = ERR_DATA_DEF,
  parameter int               CNT_W       = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic             s_ack_i,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             to_clr_i,
  output logic             to_flag_o,
  output logic [CNT_W-1:0] to_cnt_o,
  output logic [1:0]       gnt_o
);
  state_t     state_q, state_d;
  logic       last_q;
  wb_req_t    m0_req, m1_req, g_req;
  logic       req, timeout, ack_g;
  logic [DAT_W-1:0] rsp_dat;

  assign m0_req = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
  assign m1_req = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == GNT0 && state_d != GNT0) last_q <= 1'b0;
      if (state_q == GNT1 && state_d != GNT1) last_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    g_req = '0;
    case (state_q)
      GNT0:    g_req = m0_req;
      GNT1:    g_req = m1_req;
      default: g_req = '0;
    endcase
  end

  // Strobe and cyc follow the granted master combinationally, so a dropped cyc stops the bus at once.
  assign req     = g_req.cyc & g_req.stb;
  assign s_cyc_o = g_req.cyc;
  assign s_stb_o = req & ~timeout;
  assign s_we_o  = g_req.we;
  assign s_sel_o = g_req.sel;
  assign s_adr_o = g_req.adr;
  assign s_dat_o = g_req.dat;
  assign gnt_o   = state_q;

  assign ack_g   = s_ack_i & req & ~timeout;
  assign rsp_dat = timeout ? ERR_DATA : s_dat_i;

  assign m0_ack_o = (state_q == GNT0) & ack_g;
  assign m0_err_o = (state_q == GNT0) & timeout;
  assign m0_dat_o = (state_q == GNT0) ? rsp_dat : '0;
  assign m1_ack_o = (state_q == GNT1) & ack_g;
  assign m1_err_o = (state_q == GNT1) & timeout;
  assign m1_dat_o = (state_q == GNT1) ? rsp_dat : '0;

  wb_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_wdog (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n),
    .req    (req),
    .ack    (s_ack_i),
    .gnt_chg(state_q != state_d),
    .clr    (to_clr_i),
    .timeout(timeout),
    .flag   (to_flag_o),
    .cnt    (to_cnt_o)
  );
endmodule
